// File: rtl/collatz_sweep.sv
// Sweeps starting values lo..hi through an external Collatz engine and keeps
// the starting value with the largest step count.
module collatz_sweep #(
  parameter int W  = 16,
  parameter int KW = 20,
  parameter int TO = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic [W-1:0]  lo,
  input  logic [W-1:0]  hi,
  output logic [W-1:0]  co,
  output logic          st,
  input  logic          bs,
  input  logic [KW-1:0] k,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  best_co,
  output logic [KW-1:0] best_k
);

  localparam int TW = $clog2(TO + 1) + 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    NEXT,
    FIN
  } state_t;

  state_t        state;
  logic [W-1:0]  hi_r;
  logic [KW-1:0] kcap;
  logic [TW-1:0] tcnt;

  logic [W-1:0]  lo_eff;
  logic          empty;
  logic [W:0]    nxt;

  // Zero is not a legal engine input, so a sweep from 0 starts at 1.
  always_comb begin
    lo_eff = (lo == '0) ? W'(1) : lo;
    empty  = {1'b0, lo_eff} > {1'b0, hi};
    nxt    = {1'b0, co} + (W+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hi_r    <= '0;
      kcap    <= '0;
      tcnt    <= '0;
      co      <= '0;
      st      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      best_co <= '0;
      best_k  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            hi_r    <= hi;
            best_co <= '0;
            best_k  <= '0;
            err     <= 1'b0;
            busy    <= 1'b1;
            co      <= lo_eff;
            tcnt    <= '0;
            if (empty) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              st    <= 1'b1;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          tcnt  <= tcnt + TW'(1);
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (bs) begin
            st    <= 1'b0;
            state <= WAIT_LO;
          end else if (tcnt == TW'(TO - 1)) begin
            st    <= 1'b0;
            err   <= 1'b1;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        WAIT_LO: begin
          if (!bs) begin
            kcap  <= k;
            state <= NEXT;
          end
        end
        NEXT: begin
          if (kcap > best_k) begin
            best_co <= co;
            best_k  <= kcap;
          end
          // Widened compare lets hi = all-ones finish instead of wrapping co.
          if (nxt > {1'b0, hi_r}) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            co    <= nxt[W-1:0];
            st    <= 1'b1;
            tcnt  <= '0;
            state <= ISSUE;
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collatz_sweep.sv
// Directed bench for collatz_sweep with a behavioural Collatz engine model.
module tb_collatz_sweep;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [15:0] lo = '0;
  logic [15:0] hi = '0;
  logic [15:0] co;
  logic        st;
  logic        bs;
  logic [19:0] k;
  logic        busy, done, err;
  logic [15:0] best_co;
  logic [19:0] best_k;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  collatz_sweep #(.W(16), .KW(20), .TO(16)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .lo(lo), .hi(hi),
    .co(co), .st(st), .bs(bs), .k(k),
    .busy(busy), .done(done), .err(err),
    .best_co(best_co), .best_k(best_k)
  );

  function automatic int steps(input longint unsigned n);
    int s = 0;
    while (n != 1) begin
      n = (n[0]) ? 3 * n + 1 : n / 2;
      s++;
    end
    return s;
  endfunction

  // Engine: bs rises two cycles after st is first seen, stays high 3 cycles,
  // and presents k as bs falls. With hang set it never responds.
  logic        hang = 1'b0;
  logic [1:0]  eph;
  logic [2:0]  rc;
  logic [15:0] en;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eph <= 0; bs <= 1'b0; k <= '0; rc <= 0; en <= '0;
    end else begin
      case (eph)
        2'd0: if (st && !hang) begin en <= co; eph <= 2'd1; end
        2'd1: begin bs <= 1'b1; rc <= 3'd3; eph <= 2'd2; end
        default: begin
          if (rc == 3'd1) begin
            bs <= 1'b0; k <= 20'(steps(64'(en))); eph <= 2'd0;
          end else rc <= rc - 3'd1;
        end
      endcase
    end
  end

  // Monitor: records co at each st rise, st-high cycles and done pulses.
  logic [15:0] stco[$];
  int          sthi = 0;
  int          ndone = 0;
  logic        st_q = 1'b0;
  always @(negedge clk) begin
    if (st && !st_q) stco.push_back(co);
    if (st) sthi <= sthi + 1;
    if (done) ndone <= ndone + 1;
    st_q <= st;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulses go and waits for done; returns false if done never came.
  task automatic sweep(input logic [15:0] l, input logic [15:0] h, output bit ok);
    @(negedge clk);
    lo = l; hi = h; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      if (done) ok = 1'b1;
      else @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] lo, hi;
    logic [15:0] bco;
    int          bk;     // -1: take from the reference step function
    logic        err;
    int          nst;
    logic [15:0] first;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit ok;
    int q0, d0, h0;
    vecs[0] = '{lo:16'd1,     hi:16'd10,    bco:16'd9,     bk:19,  err:1'b0, nst:10, first:16'd1};
    vecs[1] = '{lo:16'd12,    hi:16'd13,    bco:16'd12,    bk:9,   err:1'b0, nst:2,  first:16'd12};
    vecs[2] = '{lo:16'd8,     hi:16'd5,     bco:16'd0,     bk:0,   err:1'b1, nst:0,  first:16'd0};
    vecs[3] = '{lo:16'd0,     hi:16'd3,     bco:16'd3,     bk:7,   err:1'b0, nst:3,  first:16'd1};
    vecs[4] = '{lo:16'd0,     hi:16'd0,     bco:16'd0,     bk:0,   err:1'b1, nst:0,  first:16'd0};
    vecs[5] = '{lo:16'd27,    hi:16'd27,    bco:16'd27,    bk:111, err:1'b0, nst:1,  first:16'd27};
    vecs[6] = '{lo:16'd65535, hi:16'd65535, bco:16'd65535, bk:-1,  err:1'b0, nst:1,  first:16'd65535};

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_st", st, 0);
    chk("rst_best_k", best_k, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      q0 = stco.size(); d0 = ndone;
      sweep(vecs[i].lo, vecs[i].hi, ok);
      chk($sformatf("v%0d_done_seen", i), ok, 1);
      chk($sformatf("v%0d_done_once", i), ndone - d0, 1);
      chk($sformatf("v%0d_nst", i), stco.size() - q0, vecs[i].nst);
      for (int j = 0; j < vecs[i].nst && q0 + j < stco.size(); j++)
        chk($sformatf("v%0d_co%0d", i, j), stco[q0 + j], vecs[i].first + j);
      chk($sformatf("v%0d_best_co", i), best_co, vecs[i].bco);
      chk($sformatf("v%0d_best_k", i), best_k,
          (vecs[i].bk < 0) ? steps(64'(vecs[i].lo)) : vecs[i].bk);
      chk($sformatf("v%0d_err", i), err, vecs[i].err);
      chk($sformatf("v%0d_idle", i), busy, 0);
    end

    // Engine never answers: st must stay up exactly 16 cycles.
    hang = 1'b1;
    q0 = stco.size(); d0 = ndone; h0 = sthi;
    sweep(16'd3, 16'd5, ok);
    chk("to_done_seen", ok, 1);
    chk("to_done_once", ndone - d0, 1);
    chk("to_st_cycles", sthi - h0, 16);
    chk("to_nst", stco.size() - q0, 1);
    chk("to_err", err, 1);
    chk("to_best_k", best_k, 0);
    hang = 1'b0;

    // Reset in WAIT_LO mid-sweep, then a fresh single-value sweep.
    q0 = stco.size();
    @(negedge clk);
    lo = 16'd1; hi = 16'd10; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 500 && !ok; c++) begin
      if (stco.size() - q0 >= 4 && bs && !st) ok = 1'b1;
      else @(negedge clk);
    end
    chk("rst_reach_wait_lo", ok, 1);
    chk("rst_pre_best_k", (best_k != 0), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_co", co, 0);
    chk("arst_st", st, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    chk("arst_best_co", best_co, 0);
    chk("arst_best_k", best_k, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q0 = stco.size();
    repeat (10) @(negedge clk);
    chk("post_rst_no_st", stco.size() - q0, 0);
    chk("post_rst_idle", busy, 0);
    sweep(16'd5, 16'd5, ok);
    chk("fresh_done_seen", ok, 1);
    chk("fresh_best_co", best_co, 5);
    chk("fresh_best_k", best_k, 5);
    chk("fresh_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
